// File: rtl/i2s_delay_pkg.sv
// Shared definitions for the multi-channel I2S frame delay line:
// default slot geometry, channel encoding and tap arithmetic helpers.
package i2s_delay_pkg;

   // Default bits per channel slot.
   localparam int W_SLOT_DEF      = 32;

   // Default depth of the bclk/lrclk synchroniser chains.
   localparam int SYNC_STAGES_DEF = 2;

   // Channel select as carried on lrclk.
   typedef enum logic {
      CH_LEFT  = 1'b0,
      CH_RIGHT = 1'b1
   } chan_e;

   // Shift register index holding the bit that lines up with the current
   // bit position exactly `delay` frames ago. Only meaningful for delay >= 1.
   function automatic int tap_index(input int delay, input int w_slot);
      if (delay <= 0) begin
         return 0;
      end
      return (2 * w_slot * delay) - 1;
   endfunction

   // Number of bclk rises of valid history needed before a `delay`-frame
   // tap holds data captured after the last history reset.
   function automatic int fill_need(input int delay, input int w_slot);
      return 2 * w_slot * delay;
   endfunction

endpackage

// File: rtl/edge_sync.sv
// Brings an asynchronous serial clock/select pin into the clk domain and
// produces single-cycle rise/fall pulses from the synchronised level.
module edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_async,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic w_sync;
   logic r_prev;

   generate
      if (SYNC_STAGES == 0) begin : g_bypass
         assign w_sync = i_async;
      end else begin : g_chain
         logic [SYNC_STAGES-1:0] r_chain;

         // Synchroniser chain; the oldest stage is the usable level.
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               r_chain <= '0;
            end else begin
               r_chain <= (r_chain << 1) | SYNC_STAGES'(i_async);
            end
         end

         assign w_sync = r_chain[SYNC_STAGES-1];
      end
   endgenerate

   // Previous synchronised level for edge detection.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_prev <= 1'b0;
      end else begin
         r_prev <= w_sync;
      end
   end

   assign o_level = w_sync;
   assign o_rise  = w_sync & ~r_prev;
   assign o_fall  = ~w_sync & r_prev;

endmodule

// File: rtl/i2s_multi_delay.sv
// Per-channel frame delay for an I2S serial stream. Both channels share one
// interleaved bit history; each channel reads it at its own frame offset.
// Delays are latched at frame start so both channels switch together, and a
// fill counter hides history that predates the last delay increase.
module i2s_multi_delay
   import i2s_delay_pkg::*;
#(
   parameter int  MAX_DELAY   = 1,
   parameter int  W_SLOT      = W_SLOT_DEF,
   parameter int  SYNC_STAGES = SYNC_STAGES_DEF,
   localparam int DW          = $clog2(MAX_DELAY + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          bclk,
   input  logic          lrclk,
   input  logic [DW-1:0] delay_l,
   input  logic [DW-1:0] delay_r,
   input  logic          mute,
   input  logic          in,
   output logic          out,
   output logic          filled
);

   localparam int SR_LEN = 2 * W_SLOT * MAX_DELAY;
   localparam int AW     = $clog2(SR_LEN);
   localparam int FW     = $clog2(SR_LEN + 1);

   localparam logic [DW-1:0] MAX_D    = DW'(MAX_DELAY);
   localparam logic [FW-1:0] FILL_MAX = FW'(SR_LEN);

   // Synchronised pin events.
   logic w_bclk_lvl;
   logic w_bclk_rise;
   logic w_bclk_fall;
   logic w_lr_lvl;
   logic w_lr_rise;
   logic w_lr_fall;
   logic w_unused_edges;

   // State.
   logic [SR_LEN-1:0] r_sr;
   logic              r_out;
   logic [FW-1:0]     r_fill;
   logic [DW-1:0]     r_act_l;
   logic [DW-1:0]     r_act_r;
   logic              r_frame_pend;

   // Datapath.
   chan_e             w_chan;
   logic              w_load;
   logic              w_grow;
   logic [DW-1:0]     w_nxt_l;
   logic [DW-1:0]     w_nxt_r;
   logic [DW-1:0]     w_tap_d;
   logic [AW-1:0]     w_tap_idx;
   logic [DW-1:0]     w_cur_d;
   logic [FW-1:0]     w_cur_need;
   logic [DW-1:0]     w_eff_l;
   logic [DW-1:0]     w_eff_r;
   logic [DW-1:0]     w_eff_max;
   logic [FW-1:0]     w_fill_thr;

   edge_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync_bclk (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_async (bclk),
      .o_level (w_bclk_lvl),
      .o_rise  (w_bclk_rise),
      .o_fall  (w_bclk_fall)
   );

   edge_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync_lrclk (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_async (lrclk),
      .o_level (w_lr_lvl),
      .o_rise  (w_lr_rise),
      .o_fall  (w_lr_fall)
   );

   // The bclk level and lrclk rise are not needed by the datapath.
   assign w_unused_edges = w_bclk_lvl ^ w_lr_rise;

   assign w_chan = chan_e'(w_lr_lvl);

   // A frame starts at the lrclk fall; the delays are taken at the first
   // bclk fall from then on, which may be in the very same cycle.
   assign w_load  = w_bclk_fall & (r_frame_pend | w_lr_fall);
   assign w_nxt_l = w_load ? delay_l : r_act_l;
   assign w_nxt_r = w_load ? delay_r : r_act_r;

   // A longer delay reaches further back than the history gathered so far.
   assign w_grow  = w_load & ((delay_l > r_act_l) | (delay_r > r_act_r));

   // The tap read at a frame-start fall must already use the new delay.
   assign w_tap_d = (w_chan == CH_RIGHT) ? w_nxt_r : w_nxt_l;

   // Tap index, clamped for delays that never select a stored bit.
   always_comb begin
      w_tap_idx = '0;
      if ((w_tap_d != '0) && (w_tap_d <= MAX_D)) begin
         w_tap_idx = AW'(tap_index(32'(w_tap_d), W_SLOT));
      end
   end

   // Frame-start tracking: armed by an lrclk fall, consumed by the load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_frame_pend <= 1'b0;
      end else if (w_load) begin
         r_frame_pend <= 1'b0;
      end else if (w_lr_fall) begin
         r_frame_pend <= 1'b1;
      end
   end

   // Active delays, switched together at frame start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_act_l <= '0;
         r_act_r <= '0;
      end else if (w_load) begin
         r_act_l <= delay_l;
         r_act_r <= delay_r;
      end
   end

   // Interleaved bit history, newest bit at index 0; never cleared by
   // delay changes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sr <= '0;
      end else if (w_bclk_rise) begin
         r_sr <= {r_sr[SR_LEN-2:0], in};
      end
   end

   // Delayed bit captured on the bclk fall so it changes with the stream.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out <= 1'b0;
      end else if (w_bclk_fall) begin
         r_out <= r_sr[w_tap_idx];
      end
   end

   // History depth counter; a delay increase restarts it and wins over a
   // coincident bclk rise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fill <= '0;
      end else if (w_grow) begin
         r_fill <= '0;
      end else if (w_bclk_rise && (r_fill != FILL_MAX)) begin
         r_fill <= r_fill + FW'(1);
      end
   end

   // Delay and history requirement of the slot currently on the wire.
   assign w_cur_d    = (w_chan == CH_RIGHT) ? r_act_r : r_act_l;
   assign w_cur_need = FW'(fill_need(32'(w_cur_d), W_SLOT));

   // Output select: mute, bypass, out-of-range, not-yet-filled, delayed.
   always_comb begin
      out = r_out;
      if (mute) begin
         out = 1'b0;
      end else if (w_cur_d == '0) begin
         out = in;
      end else if (w_cur_d > MAX_D) begin
         out = 1'b0;
      end else if (r_fill < w_cur_need) begin
         out = 1'b0;
      end
   end

   // Out-of-range delays need no history, so they count as zero here.
   assign w_eff_l    = (r_act_l > MAX_D) ? '0 : r_act_l;
   assign w_eff_r    = (r_act_r > MAX_D) ? '0 : r_act_r;
   assign w_eff_max  = (w_eff_l > w_eff_r) ? w_eff_l : w_eff_r;
   assign w_fill_thr = FW'(fill_need(32'(w_eff_max), W_SLOT));
   assign filled     = (r_fill >= w_fill_thr);

endmodule

// File: tb/tb_i2s_multi_delay.sv
// Directed bench for i2s_multi_delay with MAX_DELAY=2, W_SLOT=8.
// One bit period is 8 clk: bclk falls (data/lrclk change), rises 4 clk
// later, and outputs are sampled 3 clk after the rise.
module tb_i2s_multi_delay;

   localparam int W = 8;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst_n;
   logic       bclk;
   logic       lrclk;
   logic [1:0] delay_l;
   logic [1:0] delay_r;
   logic       mute;
   logic       in_s;
   logic       out_s;
   logic       filled;

   always #5 clk = ~clk;

   i2s_multi_delay #(
      .MAX_DELAY   (2),
      .W_SLOT      (W),
      .SYNC_STAGES (2)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bclk    (bclk),
      .lrclk   (lrclk),
      .delay_l (delay_l),
      .delay_r (delay_r),
      .mute    (mute),
      .in      (in_s),
      .out     (out_s),
      .filled  (filled)
   );

   // ---------------- scoreboard ----------------
   int              n_cmp = 0;
   int              n_err = 0;
   logic [W-1:0]    exp_q[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic score_slot(input string tag, input logic [W-1:0] got);
      logic [W-1:0] e;
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s: scoreboard empty, got 0x%0h", tag, got);
      end else begin
         e = exp_q.pop_front();
         check_eq(tag, {24'd0, got}, {24'd0, e});
      end
   endtask

   // ---------------- drivers ----------------
   task automatic bit_period(input logic b, input logic lr, input logic m,
                             output logic o, output logic f);
      @(negedge clk);
      bclk  = 1'b0;
      lrclk = lr;
      in_s  = b;
      mute  = m;
      repeat (4) @(negedge clk);
      bclk = 1'b1;
      repeat (3) @(negedge clk);
      o = out_s;
      f = filled;
   endtask

   task automatic send_slot(input logic [W-1:0] d, input logic lr, input logic [W-1:0] mmask,
                            input int chg_at, input logic [1:0] chg_val,
                            output logic [W-1:0] o, output logic f_first, output logic f_last);
      logic ob;
      logic fb;
      for (int i = 0; i < W; i++) begin
         if (i == chg_at) delay_l = chg_val;
         bit_period(d[W-1-i], lr, mmask[W-1-i], ob, fb);
         o[W-1-i] = ob;
         if (i == 0) f_first = fb;
         if (i == W-1) f_last = fb;
      end
   endtask

   task automatic run_frame(input string tag, input logic [W-1:0] l, input logic [W-1:0] r,
                            input logic [W-1:0] mmask, input int chg_at, input logic [1:0] chg_val,
                            input logic chk_l, input logic [W-1:0] el,
                            input logic chk_r, input logic [W-1:0] er,
                            output logic ff, output logic fl);
      logic [W-1:0] ol;
      logic [W-1:0] orr;
      logic         fdum;
      if (chk_l) exp_q.push_back(el);
      if (chk_r) exp_q.push_back(er);
      send_slot(l, 1'b0, mmask, chg_at, chg_val, ol, ff, fdum);
      send_slot(r, 1'b1, '0, -1, 2'd0, orr, fdum, fl);
      if (chk_l) score_slot({tag, "_left"}, ol);
      if (chk_r) score_slot({tag, "_right"}, orr);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   // ---------------- stimulus ----------------
   initial begin
      logic         ff;
      logic         fl;
      logic         ob;
      logic         fb;
      logic [W-1:0] dummy;
      logic [W-1:0] rv;

      rst_n   = 1'b0;
      bclk    = 1'b1;
      lrclk   = 1'b1;
      mute    = 1'b0;
      in_s    = 1'b1;
      delay_l = 2'd0;
      delay_r = 2'd0;

      // Reset: bypass and filled.
      #1;
      check_eq("rst_out_hi", {31'd0, out_s}, 32'd1);
      in_s = 1'b0;
      #1;
      check_eq("rst_out_lo", {31'd0, out_s}, 32'd0);
      check_eq("rst_filled", {31'd0, filled}, 32'd1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      in_s = 1'b1;
      #1;
      check_eq("post_rst_bypass", {31'd0, out_s}, 32'd1);

      // Left delayed one frame, right passes through.
      delay_l = 2'd1;
      delay_r = 2'd0;
      send_slot(8'h00, 1'b1, '0, -1, 2'd0, dummy, ff, fl);

      run_frame("f1", 8'h01, 8'hA1, '0, -1, 2'd0, 1'b1, 8'h00, 1'b1, 8'hA1, ff, fl);
      check_eq("f1_filled_first", {31'd0, ff}, 32'd0);
      check_eq("f1_filled_last", {31'd0, fl}, 32'd1);
      run_frame("f2", 8'h02, 8'hA2, '0, -1, 2'd0, 1'b1, 8'h01, 1'b1, 8'hA2, ff, fl);
      run_frame("f3", 8'h03, 8'hA3, '0, -1, 2'd0, 1'b1, 8'h02, 1'b1, 8'hA3, ff, fl);
      run_frame("f4", 8'hFF, 8'hA4, '0, -1, 2'd0, 1'b1, 8'h03, 1'b1, 8'hA4, ff, fl);

      // Mute over left bits 2..6, then history still intact.
      run_frame("f5_mute", 8'h5A, 8'hA5, 8'h3E, -1, 2'd0, 1'b1, 8'hC1, 1'b1, 8'hA5, ff, fl);
      run_frame("f6", 8'h3C, 8'hA6, '0, -1, 2'd0, 1'b1, 8'h5A, 1'b1, 8'hA6, ff, fl);

      // delay_l 1->2 mid-left-slot: no effect until next frame, then refill.
      run_frame("f7_chg", 8'h11, 8'hA7, '0, 3, 2'd2, 1'b1, 8'h3C, 1'b1, 8'hA7, ff, fl);
      run_frame("f8", 8'h22, 8'hA8, '0, -1, 2'd0, 1'b1, 8'h00, 1'b1, 8'hA8, ff, fl);
      check_eq("f8_filled_first", {31'd0, ff}, 32'd0);
      run_frame("f9", 8'h33, 8'hA9, '0, -1, 2'd0, 1'b1, 8'h00, 1'b1, 8'hA9, ff, fl);
      check_eq("f9_filled_first", {31'd0, ff}, 32'd0);
      check_eq("f9_filled_last", {31'd0, fl}, 32'd1);
      run_frame("f10", 8'h44, 8'hAA, '0, -1, 2'd0, 1'b1, 8'h22, 1'b1, 8'hAA, ff, fl);

      // delay_l 2->1: no gap, previous frame appears at once.
      delay_l = 2'd1;
      run_frame("f11", 8'h55, 8'hAB, '0, -1, 2'd0, 1'b1, 8'h44, 1'b1, 8'hAB, ff, fl);
      check_eq("f11_filled_first", {31'd0, ff}, 32'd1);

      // Out-of-range delays: silence, filled stays high.
      delay_l = 2'd3;
      delay_r = 2'd3;
      run_frame("f12_oor", 8'h66, 8'hAC, '0, -1, 2'd0, 1'b1, 8'h00, 1'b1, 8'h00, ff, fl);
      check_eq("f12_filled_first", {31'd0, ff}, 32'd1);
      check_eq("f12_filled_last", {31'd0, fl}, 32'd1);

      // Back to 1/0: decrease, history from the muted-out frame is shown.
      delay_l = 2'd1;
      delay_r = 2'd0;
      run_frame("f13", 8'h77, 8'hAD, '0, -1, 2'd0, 1'b1, 8'h66, 1'b1, 8'hAD, ff, fl);
      check_eq("f13_filled_first", {31'd0, ff}, 32'd1);

      // Frame 14: normal left slot, reset in the middle of the right slot.
      exp_q.push_back(8'h77);
      send_slot(8'h88, 1'b0, '0, -1, 2'd0, dummy, ff, fl);
      score_slot("f14_left", dummy);
      rv = 8'hAE;
      for (int i = 0; i < W; i++) begin
         if (i == 3) begin
            #2;
            rst_n = 1'b0;
            in_s  = 1'b1;
            #1;
            check_eq("midrst_out_hi", {31'd0, out_s}, 32'd1);
            in_s = 1'b0;
            #1;
            check_eq("midrst_out_lo", {31'd0, out_s}, 32'd0);
            check_eq("midrst_filled", {31'd0, filled}, 32'd1);
         end
         if (i == 5) begin
            #2;
            rst_n = 1'b1;
         end
         bit_period(rv[W-1-i], 1'b1, 1'b0, ob, fb);
         check_eq($sformatf("f14_right_bit%0d", i), {31'd0, ob}, {31'd0, rv[W-1-i]});
      end

      // After reset the delay returns within two frame starts.
      run_frame("f15", 8'h12, 8'hB1, '0, -1, 2'd0, 1'b0, 8'h00, 1'b1, 8'hB1, ff, fl);
      run_frame("f16", 8'h34, 8'hB2, '0, -1, 2'd0, 1'b0, 8'h00, 1'b1, 8'hB2, ff, fl);
      run_frame("f17", 8'h56, 8'hB3, '0, -1, 2'd0, 1'b1, 8'h34, 1'b1, 8'hB3, ff, fl);
      check_eq("f17_filled_last", {31'd0, fl}, 32'd1);

      check_eq("scoreboard_drained", exp_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/i2s_multi_delay.md
I2S_MULTI_DELAY -- requirements
Module: i2s_multi_delay

Interface
REQ-001 Parameter MAX_DELAY, default 1: maximum delay per channel, in frames, >=1.
REQ-002 Parameter W_SLOT, default 32: bits per channel slot.
REQ-003 Parameter SYNC_STAGES, default 2: synchroniser depth for bclk/lrclk, 0 = no synchroniser.
REQ-004 Parameter DW (derived, not overridable) = $clog2(MAX_DELAY+1).
REQ-005 clk  input  1  system clock, all flops on posedge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 bclk  input  1  serial bit clock, slower than clk/4.
REQ-008 lrclk  input  1  channel select, 0 = left slot, 1 = right slot.
REQ-009 delay_l  input  DW  requested left delay in frames.
REQ-010 delay_r  input  DW  requested right delay in frames.
REQ-011 mute  input  1  forces out to 0 while high.
REQ-012 in  input  1  serial data in.
REQ-013 out  output  1  serial data out.
REQ-014 filled  output  1  high when the delay buffer holds enough valid history for both active delays.

Function
REQ-015 bclk and lrclk SHALL pass SYNC_STAGES flops, then a 1-flop edge detector; all edge events refer to the synchronised signals.
REQ-016 On bclk rising edge the block SHALL shift in into a single interleaved shift register of length 2*W_SLOT*MAX_DELAY (newest bit at index 0).
REQ-017 On bclk falling edge the block SHALL register out_reg from tap index 2*W_SLOT*d-1, with d = active delay of channel given by current synchronised lrclk.
REQ-018 Active delays act_l/act_r SHALL load from delay_l/delay_r only on the first bclk falling edge after a synchronised lrclk falling edge (frame start); both channels switch in the same frame.
REQ-019 Out mux per current channel: mute=1 -> 0; d=0 -> in (combinational bypass); d>MAX_DELAY -> 0; fill < 2*W_SLOT*d -> 0; else out_reg.
REQ-020 Fill counter SHALL count bclk rising edges, saturating at 2*W_SLOT*MAX_DELAY; width $clog2(2*W_SLOT*MAX_DELAY+1).
REQ-021 When a load per REQ-018 changes act_l or act_r to a value larger than before, the fill counter SHALL clear to 0 in that cycle; unchanged or smaller values leave it untouched.
REQ-022 filled = fill >= 2*W_SLOT*max(act_l,act_r), treating any act > MAX_DELAY as 0.
REQ-023 Simultaneous bclk edge and fill clear in one clk: clear wins, count restarts on next rising edge.
REQ-024 Latency: out_reg valid 1 clk after synchronised bclk falling edge, i.e. SYNC_STAGES+2 clk after the pin edge.
REQ-025 Shift register contents SHALL NOT be cleared by delay changes; only the fill gating hides stale data.

Reset
REQ-026 rst_n low SHALL asynchronously clear shift register, out_reg, fill, act_l, act_r, synchroniser and edge flops to 0.
REQ-027 During and after reset until the first load, out = in when mute=0 (act=0 bypass); filled = 1.
REQ-028 Reset mid-frame: first delay load occurs at the next full frame start, never a partial one.

Structure
REQ-029 Package i2s_delay_pkg SHALL hold W_SLOT default, SYNC_STAGES default and a function computing tap index from (delay, W_SLOT).
REQ-030 One sub-module edge_sync (synchroniser + rise/fall pulses, parameter SYNC_STAGES), instantiated for bclk and lrclk.
REQ-031 No memories; plain flops only, RTL 120-400 lines.

Verification
REQ-032 MAX_DELAY=2, delay_l=1, delay_r=0, ramp left samples 1,2,3 -> left out 0 in frame 1, then 1,2; right out equals right in same frame.
REQ-033 delay_l=delay_r=3 with MAX_DELAY=2 -> out constant 0, filled=1.
REQ-034 Change delay_l 1->2 mid-left-slot -> switch happens at next frame start, filled low 2*W_SLOT*2 bclk rises, out 0 during refill.
REQ-035 Change delay_l 2->1 -> filled stays 1, output shows sample from 1 frame earlier with no gap.
REQ-036 mute pulse 5 bclk periods in delayed mode -> out 0 exactly during mute, shift history preserved after release.
REQ-037 rst_n asserted mid-right-slot with delay 1 -> out=in immediately, delay re-applied at second lrclk falling edge after release.
